// File: rtl/yadmc_pkg.sv
// Shared constants and state encoding for the memory-test master and related bring-up blocks.
`default_nettype none
package yadmc_pkg;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [3:0]  SEL_ALL   = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    GAP_W = 3'd2,
    RD    = 3'd3,
    GAP_R = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/memtest_lfsr32.sv
// 32-bit Galois LFSR with synchronous reload to SEED and single-step advance.
`default_nettype none
module memtest_lfsr32
  import yadmc_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] value
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 32'h0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_memtest_master.sv
// Wishbone master that writes an LFSR pattern over a word range, reads it back and reports the result.
`default_nettype none
module wb_memtest_master
  import yadmc_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h00000000,
  parameter int          NWORDS   = 800,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] SEED     = 32'h1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [19:0] err_count,
  output logic [31:0] first_err_adr,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i
);

  localparam int IDX_W = 21;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [IDX_W-1:0]  index;
  logic [TO_W-1:0]   to_cnt;
  logic [31:0]       lfsr;
  logic              lfsr_load, lfsr_adv;
  logic              pass_held;
  logic              access, ack_ok, last_word, to_hit, pass_now, mismatch;
  logic [31:0]       cur_adr;

  memtest_lfsr32 #(.SEED(SEED)) u_lfsr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .value     (lfsr)
  );

  assign access    = (state == WR) || (state == RD);
  assign ack_ok    = access && wb_ack_i;
  assign last_word = (index == IDX_W'(NWORDS));
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT - 1));
  assign cur_adr   = BASE_ADR + (32'(index) << 2);
  assign mismatch  = (state == RD) && wb_ack_i && (wb_dat_i != lfsr);
  assign pass_now  = (err_count == 20'h0) && !timeout;

  always_comb begin
    state_next = state;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lfsr_load  = 1'b1;
          state_next = WR;
        end
      end
      WR, RD: begin
        if (wb_ack_i) begin
          lfsr_adv   = 1'b1;
          state_next = (state == WR) ? GAP_W : GAP_R;
        end else if (to_hit) begin
          state_next = FIN;
        end
      end
      GAP_W: begin
        if (last_word) begin
          lfsr_load  = 1'b1;
          state_next = RD;
        end else begin
          state_next = WR;
        end
      end
      GAP_R:   state_next = last_word ? FIN : RD;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cycle counter runs only while a strobe is out, so it is zero on every WR/RD entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      index  <= '0;
      to_cnt <= '0;
    end else begin
      to_cnt <= access ? to_cnt + 1'b1 : '0;
      if ((state == IDLE && start) || (state == GAP_W && last_word)) begin
        index <= '0;
      end else if (ack_ok) begin
        index <= index + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_count     <= '0;
      first_err_adr <= '0;
      timeout       <= 1'b0;
      pass_held     <= 1'b0;
    end else if (state == IDLE && start) begin
      err_count     <= '0;
      first_err_adr <= '0;
      timeout       <= 1'b0;
      pass_held     <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_count != 20'hFFFFF) err_count <= err_count + 1'b1;
        if (err_count == 20'h0) first_err_adr <= cur_adr;
      end
      if (access && !wb_ack_i && to_hit) timeout <= 1'b1;
      if (state == FIN) pass_held <= pass_now;
    end
  end

  assign busy     = (state == WR) || (state == GAP_W) || (state == RD) || (state == GAP_R);
  assign done     = (state == FIN);
  assign pass     = (state == FIN) ? pass_now : pass_held;
  assign wb_cyc_o = access;
  assign wb_stb_o = access;
  assign wb_we_o  = (state == WR);
  assign wb_sel_o = access ? SEL_ALL : 4'h0;
  assign wb_adr_o = access ? cur_adr : 32'h0;
  assign wb_dat_o = (state == WR) ? lfsr : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_wb_memtest_master.sv
// Bench for wb_memtest_master: RAM slave model with wait states, bit corruption and ack suppression.
`default_nettype none
module tb_wb_memtest_master;

  localparam int          NW   = 8;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] SD   = 32'h1;
  localparam logic [31:0] MASK = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [19:0] err_count;
  logic [31:0] first_err_adr, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;

  wb_memtest_master #(.BASE_ADR(BASE), .NWORDS(NW), .TIMEOUT(TO), .SEED(SD)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count), .first_err_adr(first_err_adr),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: ack after wait_n strobe cycles, optional corruption of bit 3 on word 5.
  logic [31:0] mem [0:15];
  logic        ack_en = 1'b1;
  logic        flip_en = 1'b0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic [3:0]  idx;

  assign idx      = wb_adr_o[5:2];
  assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en && (wcnt == wait_n);
  assign wb_dat_i = (wb_cyc_o && !wb_we_o) ?
                    (mem[idx] ^ ((flip_en && idx == 4'd5) ? 32'h8 : 32'h0)) : 32'h0;

  always @(posedge clk) begin
    wcnt <= (wb_cyc_o && !wb_ack_i) ? wcnt + 1 : 0;
    if (wb_cyc_o && wb_we_o && wb_ack_i) mem[idx] <= wb_dat_o;
  end

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } acc_t;
  acc_t exp_q[$];

  task automatic push_run();
    logic [31:0] v;
    for (int pass_n = 0; pass_n < 2; pass_n++) begin
      v = SD;
      for (int i = 0; i < NW; i++) begin
        exp_q.push_back('{adr: BASE + 32'(i) * 4, we: (pass_n == 0), dat: v});
        v = (v >> 1) ^ (v[0] ? MASK : 32'h0);
      end
    end
  endtask

  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    acc_t e;
    if (!rst_n) begin
      prev_ack = 1'b0;
    end else begin
      if (prev_ack) check("gap_cyc_low", {63'h0, wb_cyc_o}, 64'h0);
      prev_ack = wb_cyc_o && wb_ack_i;
      if (wb_cyc_o && wb_ack_i) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_access", 64'(wb_adr_o), 64'hFFFFFFFF_FFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("acc_adr", 64'(wb_adr_o), 64'(e.adr));
          check("acc_we", 64'(wb_we_o), 64'(e.we));
          check("acc_sel", 64'({wb_stb_o, wb_sel_o}), 64'h1F);
          if (e.we) check("acc_wdat", 64'(wb_dat_o), 64'(e.dat));
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc_n, output int cyc_hi);
    bit seen = 1'b0;
    cyc_n  = 0;
    cyc_hi = 0;
    while (!seen && cyc_n < 2000) begin
      if (wb_cyc_o) cyc_hi++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1 cyc_n++;
      end
    end
    if (!seen) check("done_seen", 64'h0, 64'h1);
  endtask

  int cn, ch;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 64'({busy, done, pass, timeout, wb_cyc_o, wb_stb_o, wb_we_o}), 64'h0);
    check("rst_err_count", 64'(err_count), 64'h0);
    check("rst_first_err", 64'(first_err_adr), 64'h0);
    check("rst_bus", 64'({wb_adr_o, wb_sel_o}), 64'h0);
    @(negedge clk) rst_n = 1'b1;

    // Zero-wait run.
    push_run();
    ack_cnt = 0;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'h1);
    wait_done(cn, ch);
    check("zw_cycles", 64'(cn), 64'(4 * NW));
    check("zw_pass", 64'(pass), 64'h1);
    check("zw_err_count", 64'(err_count), 64'h0);
    check("zw_timeout", 64'(timeout), 64'h0);
    check("zw_acks", 64'(ack_cnt), 64'(2 * NW));
    check("zw_queue_empty", 64'(exp_q.size()), 64'h0);
    @(posedge clk);
    #1;
    check("zw_done_pulse", 64'({done, busy}), 64'h0);
    check("zw_pass_hold", 64'(pass), 64'h1);

    // Two wait states per access, bit 3 of word 5 corrupted on read.
    push_run();
    ack_cnt = 0;
    wait_n  = 2;
    flip_en = 1'b1;
    pulse_start();
    wait_done(cn, ch);
    check("err_cycles", 64'(cn), 64'(2 * NW * (2 + 2)));
    check("err_pass", 64'(pass), 64'h0);
    check("err_count", 64'(err_count), 64'h1);
    check("err_first_adr", 64'(first_err_adr), 64'h14);
    check("err_acks", 64'(ack_cnt), 64'(2 * NW));
    repeat (2) @(posedge clk);
    #1;
    check("err_hold", 64'({pass, err_count, first_err_adr}), {11'h0, 1'b0, 20'h1, 32'h14});

    // Slave never acks.
    ack_en  = 1'b0;
    flip_en = 1'b0;
    wait_n  = 0;
    ack_cnt = 0;
    pulse_start();
    check("to_err_cleared", 64'({err_count, first_err_adr}), 64'h0);
    wait_done(cn, ch);
    check("to_cycles", 64'(cn), 64'(TO));
    check("to_cyc_high", 64'(ch), 64'(TO));
    check("to_flags", 64'({timeout, pass}), 64'h2);
    repeat (4) @(posedge clk);
    #1;
    check("to_idle", 64'({wb_cyc_o, busy, timeout}), 64'h1);
    check("to_acks", 64'(ack_cnt), 64'h0);

    // Asynchronous reset during the read phase.
    ack_en = 1'b1;
    push_run();
    pulse_start();
    repeat (2 * NW + 3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_bus", 64'({wb_cyc_o, wb_stb_o, busy, timeout}), 64'h0);
    check("arst_results", 64'({pass, err_count, first_err_adr}), 64'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fresh run with extra start pulses while busy.
    push_run();
    ack_cnt = 0;
    pulse_start();
    repeat (5) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #1;
    wait_done(cn, ch);
    check("rs_pass", 64'(pass), 64'h1);
    check("rs_acks", 64'(ack_cnt), 64'(2 * NW));
    check("rs_queue_empty", 64'(exp_q.size()), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rs_idle", 64'({busy, wb_cyc_o}), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_memtest_master.md
Name: wb_memtest_master

Overview:
- Self-contained Wishbone master sitting directly upstream of the yadmc SDRAM controller's Wishbone slave port.
- On start, fills a word range with an LFSR pattern, reads it back, checks it, and reports pass/fail, error count and first failing address.
- Used for board bring-up and regression; replaces hand-driven bus tasks once SDRAM initialisation is complete.

Parameters:
- BASE_ADR, 32'h00000000, byte address of first word (word aligned).
- NWORDS, 800, number of 32-bit words tested (1..2^20).
- TIMEOUT, 1024, max cycles waiting for wb_ack_i per access before abort.
- SEED, 32'h1, LFSR seed; must be non-zero.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a test when idle.
- busy  out  1  high from start accepted until done.
- done  out  1  one-cycle pulse at end of test.
- pass  out  1  valid after done: 1 if err_count==0 and no timeout.
- timeout  out  1  sticky until next start: access aborted.
- err_count  out  20  number of mismatching read words, saturating.
- first_err_adr  out  32  byte address of first mismatch (0 if none).
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  always 4'hF during access.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe, equal to wb_cyc_o.
- wb_we_o  out  1  write enable.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset: all outputs 0. State IDLE. LFSR = SEED, index = 0.
- LFSR: 32-bit Galois, taps 32,22,2,1 (mask 32'h80200003). Advances once per acked access.
- IDLE:
  - start -> load LFSR=SEED, index=0, clear err_count/first_err_adr/timeout/pass, busy=1 -> WR.
  - start while busy is ignored.
- WR:
  - Drive cyc=stb=we=1, adr=BASE_ADR+4*index, dat=LFSR.
  - Hold all signals stable until wb_ack_i is sampled high.
  - On ack: deassert cyc/stb next cycle (slave needs ack release), advance LFSR, index++ -> GAP_W.
- GAP_W: one idle cycle, cyc=0.
  - If index==NWORDS: reset index=0, LFSR=SEED -> RD.
  - Else -> WR.
- RD:
  - cyc=stb=1, we=0, same address sequence.
  - On ack, compare wb_dat_i against LFSR in the same cycle.
  - On mismatch: err_count++ (saturate at 20'hFFFFF); if err_count was 0, capture first_err_adr.
  - Advance LFSR, index++ -> GAP_R.
- GAP_R: as GAP_W.
  - At index==NWORDS -> FIN.
- FIN: done=1 for one cycle, pass=(err_count==0), busy=0 -> IDLE. pass/err_count/first_err_adr hold until the next start.
- Timeout:
  - A per-access cycle counter is cleared on entry to WR/RD.
  - Reaching TIMEOUT without ack: drop cyc/stb, set timeout=1, pass=0 -> FIN.
- Ack outside an active cycle (cyc=0) is ignored.
- Bus timing: minimum access is 2 cycles including the gap. Ack in the first strobe cycle is legal.
- Async reset mid-test: immediately drops cyc/stb and returns all outputs to reset values. No partial results are retained.
- Address arithmetic is 32-bit, wrapping modulo 2^32; no overflow check.

Decomposition:
- Shared package (yadmc_pkg): LFSR mask constant; Wishbone SEL_ALL=4'hF; state encoding localparams (IDLE, WR, GAP_W, RD, GAP_R, FIN).
- One sub-module, memtest_lfsr32: load, advance, 32-bit value; reused by other bring-up blocks.
- FSM, counters and checker stay in the top.

Test Plan:
- Zero-wait RAM model, NWORDS=4, SEED=1: 4 writes then 4 reads of 1, 0x80200003, …; done after 16 cycles; pass=1, err_count=0.
- yadmc + mt48lc16m16a2 after 6000 init cycles, NWORDS=800: pass=1. cyc never high during GAP cycles; adr sequence is 0x0..0xC7C, twice.
- RAM model with stuck bit 3 on word 5 (adr 0x14): pass=0, err_count=1, first_err_adr=0x14.
- Slave never acks, TIMEOUT=16: cyc drops after 16 cycles, timeout=1, done pulse, pass=0, no further accesses.
- Assert sys_rst_n low during the read phase: cyc/stb/busy=0 asynchronously. A new start after release gives a full fresh pass=1 run.
- start pulses while busy: ignored; test completes normally with exactly 2*NWORDS acks counted.
